// File: rtl/stall_absorbing_fifo_pkg.sv
// Shared helpers for the stall-absorbing FIFO: almostFull threshold and
// the legality rule for the producer round-trip latency.
package stall_absorbing_fifo_pkg;

  function automatic int unsigned almostFullThreshold(input int unsigned depthLog2,
                                                      input int unsigned pipeLatency);
    return (32'd1 << depthLog2) - pipeLatency;
  endfunction

  // In-flight words must fit below capacity with margin for the output register.
  function automatic bit pipeLatencyLegal(input int unsigned depthLog2,
                                          input int unsigned pipeLatency);
    return (pipeLatency + 32'd2) <= (32'd1 << depthLog2);
  endfunction

endpackage

// File: rtl/stall_absorbing_fifo_if.sv
// Producer-side valid/data plus consumer-side valid/ready bundle of the FIFO.
interface stall_absorbing_fifo_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
);
  logic                  writeValid;
  logic [WIDTH-1:0]      writeData;
  logic                  almostFull;
  logic                  readValid;
  logic [WIDTH-1:0]      readData;
  logic                  readReady;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflowError;

  modport master (
    output writeValid, writeData, readReady,
    input  almostFull, readValid, readData, count, overflowError
  );

  modport slave (
    input  writeValid, writeData, readReady,
    output almostFull, readValid, readData, count, overflowError
  );
endinterface

// File: rtl/stall_absorbing_fifo_dualport_storage.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Kept free of reset and control so it maps onto distributed RAM.
module stall_absorbing_fifo_dualport_storage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [WIDTH-1:0]      dataIn,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic [WIDTH-1:0]      dataOut
);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (writeEnable) begin
      mem[writeAddr] <= dataIn;
    end
  end

  assign dataOut = mem[readAddr];
endmodule

// File: rtl/stall_absorbing_fifo.sv
// Absorbs a non-stallable valid/data hyperpipe into a valid/ready stream,
// raising a registered almostFull early enough to cover in-flight writes.
module stall_absorbing_fifo
  import stall_absorbing_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH_LOG2   = 5,
  parameter int unsigned PIPE_LATENCY = 4
) (
  input logic                  clk,
  input logic                  rst,
  stall_absorbing_fifo_if.slave bus
);
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned PW        = DEPTH_LOG2 + 1;
  localparam int unsigned THRESHOLD = almostFullThreshold(DEPTH_LOG2, PIPE_LATENCY);

  if (!pipeLatencyLegal(DEPTH_LOG2, PIPE_LATENCY)) begin : g_bad_pipe_latency
    $error("stall_absorbing_fifo: PIPE_LATENCY must not exceed DEPTH-2");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    mem_count;
  logic [PW-1:0]    count_q;
  logic [PW-1:0]    count_next;
  logic             read_valid_q;
  logic [WIDTH-1:0] read_data_q;
  logic             almost_full_q;
  logic             overflow_q;
  logic             pop;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] mem_rd_data;

  // Extra pointer MSB separates full from empty; subtraction wraps naturally.
  always_comb begin
    mem_count  = wr_ptr - rd_ptr;
    pop        = read_valid_q & bus.readReady;
    load       = (mem_count != '0) & (~read_valid_q | pop);
    accept     = bus.writeValid & ((mem_count < PW'(DEPTH)) | load);
    count_next = count_q + PW'(accept) - PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      read_valid_q  <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (load) begin
        rd_ptr       <= rd_ptr + PW'(1);
        read_valid_q <= 1'b1;
      end else if (pop) begin
        read_valid_q <= 1'b0;
      end
      count_q       <= count_next;
      almost_full_q <= (count_next >= PW'(THRESHOLD));
      if (bus.writeValid && !accept) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Output data register carries no reset; readValid qualifies it.
  always_ff @(posedge clk) begin
    if (!rst && load) begin
      read_data_q <= mem_rd_data;
    end
  end

  stall_absorbing_fifo_dualport_storage #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_storage (
    .clk         (clk),
    .writeEnable (accept & ~rst),
    .writeAddr   (wr_ptr[DEPTH_LOG2-1:0]),
    .dataIn      (bus.writeData),
    .readAddr    (rd_ptr[DEPTH_LOG2-1:0]),
    .dataOut     (mem_rd_data)
  );

  assign bus.readValid     = read_valid_q;
  assign bus.readData      = read_data_q;
  assign bus.count         = count_q;
  assign bus.almostFull    = almost_full_q;
  assign bus.overflowError = overflow_q;
endmodule

// File: tb/tb_stall_absorbing_fifo.sv
// Self-checking bench for stall_absorbing_fifo: vector table, corner-case
// sequences and a randomized stream against a queue-based reference model.
module tb_stall_absorbing_fifo;
  localparam int unsigned WIDTH        = 8;
  localparam int unsigned DEPTH_LOG2   = 4;
  localparam int unsigned PIPE_LATENCY = 4;
  localparam int          DEPTH        = 16;
  localparam int          THR          = DEPTH - PIPE_LATENCY;

  logic clk = 1'b0;
  logic rst;

  stall_absorbing_fifo_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  stall_absorbing_fifo #(
    .WIDTH        (WIDTH),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .PIPE_LATENCY (PIPE_LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: every held word with the cycle it was written.
  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t q[$];
  int   cyc;
  logic m_af;
  logic m_ovf;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       eaf;
    logic       eovf;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  // One clock: drive inputs, compare outputs to the model, then advance both.
  task automatic step(input logic r, input logic wv, input logic [7:0] wd, input logic rr);
    logic mv;
    logic pop;
    logic acc;
    rst            = r;
    bus.writeValid = wv;
    bus.writeData  = wd;
    bus.readReady  = rr;
    // A word becomes visible two cycles after it was written, once it heads the queue.
    mv = (q.size() > 0) && (q[0].t + 2 <= cyc);
    chk("model_readValid", 32'(bus.readValid), 32'(mv));
    if (mv) chk("model_readData", 32'(bus.readData), 32'(q[0].d));
    chk("model_count", 32'(bus.count), 32'(q.size()));
    chk("model_almostFull", 32'(bus.almostFull), 32'(m_af));
    chk("model_overflow", 32'(bus.overflowError), 32'(m_ovf));
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_af  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      pop = mv && rr;
      // Only a completely full FIFO with no departure this cycle drops a write.
      acc = wv && !((q.size() == DEPTH + 1) && !pop);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{d: wd, t: cyc});
      else if (wv) m_ovf = 1'b1;
      m_af = (q.size() >= THR);
    end
    cyc++;
  endtask

  initial begin
    int   nxt;
    int   exp_idx;
    int   guard;
    logic wv;
    logic rr;
    logic af_seen;

    rst            = 1'b1;
    bus.writeValid = 1'b0;
    bus.writeData  = '0;
    bus.readReady  = 1'b0;
    q.delete();
    m_af  = 1'b0;
    m_ovf = 1'b0;
    cyc   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle, readReady on empty, then a single write with readReady held high.
    tbl[0] = '{wv: 0, wd: 8'h00, rr: 0, ev: 0, ed: 8'h00, ec: 5'd0, eaf: 0, eovf: 0};
    tbl[1] = '{wv: 0, wd: 8'h00, rr: 1, ev: 0, ed: 8'h00, ec: 5'd0, eaf: 0, eovf: 0};
    tbl[2] = '{wv: 1, wd: 8'hA5, rr: 1, ev: 0, ed: 8'h00, ec: 5'd0, eaf: 0, eovf: 0};
    tbl[3] = '{wv: 0, wd: 8'h00, rr: 1, ev: 0, ed: 8'h00, ec: 5'd1, eaf: 0, eovf: 0};
    tbl[4] = '{wv: 0, wd: 8'h00, rr: 1, ev: 1, ed: 8'hA5, ec: 5'd1, eaf: 0, eovf: 0};
    tbl[5] = '{wv: 0, wd: 8'h00, rr: 1, ev: 0, ed: 8'h00, ec: 5'd0, eaf: 0, eovf: 0};
    tbl[6] = '{wv: 0, wd: 8'h00, rr: 1, ev: 0, ed: 8'h00, ec: 5'd0, eaf: 0, eovf: 0};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("vec%0d_readValid", i), 32'(bus.readValid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_readData", i), 32'(bus.readData), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_almostFull", i), 32'(bus.almostFull), 32'(tbl[i].eaf));
      chk($sformatf("vec%0d_overflow", i), 32'(bus.overflowError), 32'(tbl[i].eovf));
      step(1'b0, tbl[i].wv, tbl[i].wd, tbl[i].rr);
    end

    // Burst of 12 crosses the threshold, 4 more reach 16 without overflow.
    for (int i = 0; i < 12; i++) begin
      if (i == 11) chk("burst_af_before_12th", 32'(bus.almostFull), 32'd0);
      step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    end
    chk("burst_count_12", 32'(bus.count), 32'd12);
    chk("burst_af_at_12", 32'(bus.almostFull), 32'd1);
    for (int i = 12; i < 16; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    chk("burst_count_16", 32'(bus.count), 32'd16);
    chk("burst_no_overflow", 32'(bus.overflowError), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_count_0", 32'(bus.count), 32'd0);
    chk("drain_af_0", 32'(bus.almostFull), 32'd0);

    // Fill to capacity, then a write with no pop must be dropped.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    chk("full_count_17", 32'(bus.count), 32'd17);
    chk("full_readValid", 32'(bus.readValid), 32'd1);
    step(1'b0, 1'b1, 8'h33, 1'b0);
    chk("drop_overflow", 32'(bus.overflowError), 32'd1);
    chk("drop_count_17", 32'(bus.count), 32'd17);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drop_sticky", 32'(bus.overflowError), 32'd1);

    // Full array with simultaneous write and pop accepts the write.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 1'b1, 8'h44, 1'b1);
    chk("full_pop_count_17", 32'(bus.count), 32'd17);
    chk("full_pop_no_overflow", 32'(bus.overflowError), 32'd0);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("full_pop_drained", 32'(bus.count), 32'd0);

    // Randomized streaming 0..99 with consumer stalls and a small backlog.
    nxt     = 0;
    exp_idx = 0;
    guard   = 0;
    af_seen = 1'b0;
    while (exp_idx < 100 && guard < 2000) begin
      wv = (nxt < 100) && (q.size() < 4);
      rr = ($urandom_range(0, 3) != 0);
      if (bus.readValid && rr) begin
        chk("stream_order", 32'(bus.readData), 32'(8'(exp_idx)));
        exp_idx++;
      end
      af_seen = af_seen | bus.almostFull;
      step(1'b0, wv, 8'(nxt), rr);
      if (wv) nxt++;
      guard++;
    end
    chk("stream_all_received", 32'(exp_idx), 32'd100);
    chk("stream_af_never", 32'(af_seen), 32'd0);

    // Reset mid-stream discards everything; a fresh word sees normal latency.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'hE0 + i), 1'b0);
    chk("pre_reset_count_9", 32'(bus.count), 32'd9);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("post_reset_count", 32'(bus.count), 32'd0);
    chk("post_reset_readValid", 32'(bus.readValid), 32'd0);
    chk("post_reset_af", 32'(bus.almostFull), 32'd0);
    step(1'b0, 1'b1, 8'h11, 1'b0);
    chk("fresh_not_yet_valid", 32'(bus.readValid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("fresh_valid", 32'(bus.readValid), 32'd1);
    chk("fresh_data", 32'(bus.readData), 32'h11);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stall_absorbing_fifo.md
Name: stall_absorbing_fifo

Overview:
- Receives a valid/data stream arriving through a fixed-latency, non-stallable hyperpipe.
- Converts that stream into a valid/ready stream for downstream consumers.
- Issues a registered almostFull early enough that writes already in flight (round trip of PIPE_LATENCY cycles) never overflow.
- Sits directly downstream of every long hyperpipe/shiftRegister data path that feeds a stallable consumer.

Parameters:
- WIDTH, 32, data word width.
- DEPTH_LOG2, 5, log2 of storage array depth; DEPTH = 2**DEPTH_LOG2.
- PIPE_LATENCY, 4, total round trip in cycles: almostFull path to the producer plus writeValid/writeData path back. Legal range 0..DEPTH-2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- writeValid  in  1  input word valid; no ready, must be accepted.
- writeData  in  WIDTH  input word.
- almostFull  out  1  registered backpressure request to the producer.
- readValid  out  1  output register holds a word.
- readData  out  WIDTH  output word, driven straight from a register.
- readReady  in  1  consumer accepts the word this cycle.
- count  out  DEPTH_LOG2+1  words held (array plus output register), registered.
- overflowError  out  1  sticky; a write was dropped.

Behaviour:
- Reset: rst sampled high at a posedge clears everything.
  - Pointers, count, readValid, almostFull and overflowError all go to 0.
  - Stored contents are discarded; readData value is don't-care.
  - writeValid and readReady are ignored in any cycle with rst high.
  - Reset mid-stream drops all held words; no partial state survives.
- Storage:
  - DEPTH-entry simple dual-port array; write is synchronous, read is asynchronous.
  - Write and read pointers are DEPTH_LOG2+1 bits, so full and empty are distinguished by the MSB.
  - memCount = wrPtr - rdPtr, modulo arithmetic.
- Output register (first-word-fall-through):
  - pop = readValid & readReady.
  - load = (memCount != 0) & (!readValid | pop).
  - On load, readData <= array[rdPtr], rdPtr increments and readValid <= 1.
  - On pop without load, readValid <= 0.
- Latency: a word written in cycle t (memory previously empty, output register empty) has readValid high in cycle t+2.
- Write acceptance:
  - A write is accepted if memCount < DEPTH or load occurs in the same cycle.
  - If accepted: array[wrPtr] <= writeData and wrPtr increments.
  - If rejected: the word is dropped, overflowError <= 1 and stays 1 until rst. The pointers do not move.
- Capacity: DEPTH + 1 words total.
- Count update:
  - count <= count + accepted - pop.
  - Simultaneous accept and pop leaves count unchanged.
- almostFull:
  - Registered: almostFull <= (countNext >= DEPTH - PIPE_LATENCY), where countNext is the value count takes at the same edge.
  - Guarantee: if the producer stops writing within PIPE_LATENCY cycles of almostFull rising, overflow is impossible. Worst case is DEPTH - PIPE_LATENCY + PIPE_LATENCY = DEPTH words, one below capacity.
  - almostFull deasserts in the cycle after countNext falls below the threshold.
- Boundaries:
  - PIPE_LATENCY = 0: threshold is DEPTH.
  - Pointer wrap at 2*DEPTH is natural modulo.
  - readReady while readValid is 0 has no effect.
  - Empty-FIFO write plus readReady: the word still needs 2 cycles, with no bypass.

Decomposition:
- Package fifo_pkg holds:
  - function almostFullThreshold(depthLog2, pipeLatency), returning DEPTH - pipeLatency.
  - An elaboration-time check that PIPE_LATENCY <= DEPTH-2.
- Sub-module fifo_dualport_storage holds the storage array.
  - Ports: clk, writeEnable, writeAddr, dataIn, readAddr, dataOut (asynchronous read).
  - It is the only part mapped to MLAB; pointers, count and output register stay in the top module.

Test Plan (WIDTH=8, DEPTH_LOG2=4, PIPE_LATENCY=4; threshold 12):
- Reset then idle: all outputs 0; count=0, readValid=0, almostFull=0, overflowError=0.
- Single write 0xA5 at cycle 0, readReady=1 held: readValid=1 and readData=0xA5 at cycle 2 only; count returns to 0 at cycle 3.
- Burst of 12 writes, readReady=0: count=12, almostFull=1 on the cycle after the 12th write edge.
  - 4 more writes follow: count=16, overflowError stays 0.
  - Then drain with readReady=1: data emerges in order, and almostFull falls once count < 12.
- Fill to 17 words (array full plus output register), then write 0x33 with readReady=0: word dropped, overflowError=1, count stays 17.
- Array full, writeValid and readReady both high in the same cycle: write accepted, count unchanged at 17, no overflowError.
- Continuous write and read at full rate for 100 words with random readReady stalls (≤3 words backlog): exact in-order sequence 0..99, no loss, almostFull never asserted.
- Assert rst at count=9 while writing: next cycle all counters are 0 and readValid=0. Writing 0x11 afterwards yields 0x11 two cycles later, not stale data.
